// File: rtl/fifo_display_pacer_if.sv
// Read-side pacer bundle: FIFO pop handshake plus the display data path.
// Latency: n/a (wires only).
// Backpressure: the FIFO side is throttled purely by the pacer's pop strobe.
//
// Signals:
//   i_Fifo_Empty   FIFO empty flag (into the pacer)
//   o_Fifo_Rd_En   one-cycle pop strobe (from the pacer)
//   i_Fifo_Rd_Data registered FIFO read data, valid the cycle after the pop
//   o_Byte_Data    decoder input: {4'h0, nibble} or 8'hFF for blank
//   o_Nibble_Sel   1 while the high nibble is shown
//   o_Busy         pacer is not idle
interface fifo_display_pacer_if;
  logic       i_Fifo_Empty;
  logic       o_Fifo_Rd_En;
  logic [7:0] i_Fifo_Rd_Data;
  logic [7:0] o_Byte_Data;
  logic       o_Nibble_Sel;
  logic       o_Busy;

  // master: the pacer itself
  modport master (
    input  i_Fifo_Empty,
    input  i_Fifo_Rd_Data,
    output o_Fifo_Rd_En,
    output o_Byte_Data,
    output o_Nibble_Sel,
    output o_Busy
  );

  // slave: the FIFO / decoder environment around the pacer
  modport slave (
    output i_Fifo_Empty,
    output i_Fifo_Rd_Data,
    input  o_Fifo_Rd_En,
    input  o_Byte_Data,
    input  o_Nibble_Sel,
    input  o_Busy
  );
endinterface

// File: rtl/fifo_display_pacer.sv
// Pops bytes from the FIFO and shows high then low nibble, each for HOLD_CYCLES.
// Latency: first nibble on o_Byte_Data 2 edges after the IDLE edge that saw a non-empty FIFO.
// Backpressure: pops only from IDLE; empty flag is ignored while a byte is being shown.
//
// Ports: i_Clk, i_Rst_L (async active-low), pacer (fifo_display_pacer_if.master).
// Optional macro PACER_BLANK_GAP_EN: after the low nibble, blank (8'hFF) for
// HOLD_CYCLES cycles before returning to IDLE; otherwise the low nibble persists.
module fifo_display_pacer #(
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  fifo_display_pacer_if.master         pacer
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [7:0] BLANK = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SHOW_HI,
    S_SHOW_LO
`ifdef PACER_BLANK_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       byte_q, byte_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;

  logic cnt_done;
  assign cnt_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rd_en_d = 1'b0;
    byte_d  = byte_q;
    sel_d   = sel_q;

    case (state_q)
      S_IDLE: begin
        if (!pacer.i_Fifo_Empty) begin
          state_d = S_RD;
          rd_en_d = 1'b1;
        end
      end
      // Pop strobe is high during RD; the FIFO's registered data is valid in WAIT.
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        data_d  = pacer.i_Fifo_Rd_Data;
        byte_d  = {4'h0, pacer.i_Fifo_Rd_Data[7:4]};
        sel_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_SHOW_HI;
      end
      S_SHOW_HI: begin
        if (cnt_done) begin
          byte_d  = {4'h0, data_q[3:0]};
          sel_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHOW_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW_LO: begin
        if (cnt_done) begin
          cnt_d = '0;
`ifdef PACER_BLANK_GAP_EN
          byte_d  = BLANK;
          state_d = S_GAP;
`else
          // Last low nibble stays on the display while idle.
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PACER_BLANK_GAP_EN
      S_GAP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Busy is registered from the next state so it lines up with the state register.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rd_en_q <= 1'b0;
      byte_q  <= BLANK;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rd_en_q <= rd_en_d;
      byte_q  <= byte_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign pacer.o_Fifo_Rd_En = rd_en_q;
  assign pacer.o_Byte_Data  = byte_q;
  assign pacer.o_Nibble_Sel = sel_q;
  assign pacer.o_Busy       = busy_q;

endmodule

// File: tb/tb_fifo_display_pacer.sv
// Bench for fifo_display_pacer with HOLD_CYCLES=4: a FIFO model, a timeline
// reference model (per-byte cycle offsets), and hand-computed literal checks.
module tb_fifo_display_pacer;
  localparam int H = 4;
`ifdef PACER_BLANK_GAP_EN
  localparam int GAP = H;
  localparam int SPACING_LIT = 15;
`else
  localparam int GAP = 0;
  localparam int SPACING_LIT = 11;
`endif
  // Edges from the pop decision until the pacer is idle again.
  localparam int PERIOD = 2 * H + 2 + GAP;

  typedef logic [7:0] bq_t[$];

  logic i_Clk = 1'b0;
  logic i_Rst_L;

  fifo_display_pacer_if pif();

  fifo_display_pacer #(.HOLD_CYCLES(H)) dut (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .pacer  (pif)
  );

  always #5 i_Clk = ~i_Clk;

  logic [7:0] fq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         pops = 0;
  int         pop_cyc[$];
  logic [7:0] seen[$];
  logic [7:0] last_seen = 8'hFF;

  // Reference model: once a pop is decided, outputs follow fixed offsets.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_val = 8'h00;
  logic [7:0] m_last = 8'hFF;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      m_active = 1'b0;
      m_k      = 0;
      m_last   = 8'hFF;
    end else if (m_active) begin
      m_k = m_k + 1;
      if (m_k == PERIOD) begin
        m_active = 1'b0;
        m_last   = (GAP > 0) ? 8'hFF : {4'h0, m_val[3:0]};
      end
    end else if (!pif.i_Fifo_Empty) begin
      m_active = 1'b1;
      m_k      = 0;
      m_val    = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [7:0] eb;
    logic       es, er, ebz;
    @(negedge i_Clk);
    cyc++;
    er  = m_active && (m_k == 0);
    ebz = m_active;
    es  = m_active && (m_k >= 2) && (m_k < 2 + H);
    if (!m_active || m_k < 2) eb = m_last;
    else if (m_k < 2 + H)     eb = {4'h0, m_val[7:4]};
    else if (m_k < 2 + 2 * H) eb = {4'h0, m_val[3:0]};
    else                      eb = 8'hFF;
    chk("model_rd_en", {31'd0, pif.o_Fifo_Rd_En}, {31'd0, er});
    chk("model_busy",  {31'd0, pif.o_Busy},       {31'd0, ebz});
    chk("model_sel",   {31'd0, pif.o_Nibble_Sel}, {31'd0, es});
    chk("model_byte",  {24'd0, pif.o_Byte_Data},  {24'd0, eb});
    if (pif.o_Byte_Data !== last_seen) begin
      seen.push_back(pif.o_Byte_Data);
      last_seen = pif.o_Byte_Data;
    end
    if (pif.o_Fifo_Rd_En === 1'b1) begin
      pops++;
      pop_cyc.push_back(cyc);
      chk("pop_nonempty", {31'd0, fq.size() != 0}, 32'd1);
      if (fq.size() != 0) pif.i_Fifo_Rd_Data = fq.pop_front();
    end
    pif.i_Fifo_Empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    pif.i_Fifo_Empty = 1'b0;
  endtask

  task automatic clear_trace();
    seen.delete();
    pop_cyc.delete();
    pops = 0;
  endtask

  task automatic wait_pop(input int limit);
    int p0;
    bit ok;
    p0 = pops;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (pops != p0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pop_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_pair(input logic [7:0] b0, input logic [7:0] b1, input bq_t e, input string tag);
    clear_trace();
    push(b0);
    push(b1);
    repeat (2 * PERIOD + 12) tick();
    chk({tag, "_pops"}, pops, 32'd2);
    if (pop_cyc.size() == 2) chk({tag, "_spacing"}, pop_cyc[1] - pop_cyc[0], SPACING_LIT);
    chk({tag, "_seq_len"}, seen.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk({tag, "_seq"}, (i < seen.size()) ? {24'd0, seen[i]} : 32'hFFFF_FFFF, {24'd0, e[i]});
    chk({tag, "_busy_end"}, {31'd0, pif.o_Busy}, 32'd0);
  endtask

  initial begin
    bq_t e3, e6;
    int  p_hold;
`ifdef PACER_BLANK_GAP_EN
    e3 = '{8'h01, 8'h02, 8'hFF, 8'h03, 8'h0F, 8'hFF};
    e6 = '{8'h09, 8'h0E, 8'hFF, 8'h04, 8'h00, 8'hFF};
`else
    e3 = '{8'h01, 8'h02, 8'h03, 8'h0F};
    e6 = '{8'h09, 8'h0E, 8'h04, 8'h00};
`endif
    i_Rst_L = 1'b0;
    pif.i_Fifo_Empty = 1'b1;
    pif.i_Fifo_Rd_Data = 8'h00;

    // 1: reset values and idle with an empty FIFO
    repeat (3) tick();
    chk("rst_byte",  {24'd0, pif.o_Byte_Data},  32'hFF);
    chk("rst_rd_en", {31'd0, pif.o_Fifo_Rd_En}, 32'd0);
    chk("rst_busy",  {31'd0, pif.o_Busy},       32'd0);
    chk("rst_sel",   {31'd0, pif.o_Nibble_Sel}, 32'd0);
    i_Rst_L = 1'b1;
    clear_trace();
    repeat (100) tick();
    chk("idle_pops", pops, 32'd0);
    chk("idle_byte", {24'd0, pif.o_Byte_Data}, 32'hFF);
    chk("idle_busy", {31'd0, pif.o_Busy}, 32'd0);

    // 2: single byte 0xA5
    clear_trace();
    push(8'hA5);
    wait_pop(5);
    repeat (2) tick();
    chk("a5_hi_first", {24'd0, pif.o_Byte_Data}, 32'h0A);
    chk("a5_sel_hi",   {31'd0, pif.o_Nibble_Sel}, 32'd1);
    repeat (3) tick();
    chk("a5_hi_last",  {24'd0, pif.o_Byte_Data}, 32'h0A);
    tick();
    chk("a5_lo_first", {24'd0, pif.o_Byte_Data}, 32'h05);
    chk("a5_sel_lo",   {31'd0, pif.o_Nibble_Sel}, 32'd0);
    repeat (3) tick();
    chk("a5_lo_last",  {24'd0, pif.o_Byte_Data}, 32'h05);
    tick();
`ifdef PACER_BLANK_GAP_EN
    chk("a5_after_lo", {24'd0, pif.o_Byte_Data}, 32'hFF);
    chk("a5_busy_gap", {31'd0, pif.o_Busy}, 32'd1);
`else
    chk("a5_after_lo", {24'd0, pif.o_Byte_Data}, 32'h05);
    chk("a5_busy_idle", {31'd0, pif.o_Busy}, 32'd0);
`endif
    repeat (10) tick();
    chk("a5_pops", pops, 32'd1);
    chk("a5_busy_end", {31'd0, pif.o_Busy}, 32'd0);

    // 3: two bytes back to back
    run_pair(8'h12, 8'h3F, e3, "pair_123f");

    // 4: reset during the 2nd low-nibble cycle of 0xC7
    clear_trace();
    push(8'hC7);
    wait_pop(5);
    repeat (7) tick();
    chk("c7_lo_before_rst", {24'd0, pif.o_Byte_Data}, 32'h07);
    push(8'h3C);
    #1 i_Rst_L = 1'b0;
    #1;
    chk("c7_rst_byte",  {24'd0, pif.o_Byte_Data},  32'hFF);
    chk("c7_rst_busy",  {31'd0, pif.o_Busy},       32'd0);
    chk("c7_rst_sel",   {31'd0, pif.o_Nibble_Sel}, 32'd0);
    chk("c7_rst_rd_en", {31'd0, pif.o_Fifo_Rd_En}, 32'd0);
    p_hold = pops;
    repeat (5) tick();
    chk("c7_no_pop_in_rst", pops, p_hold);
    i_Rst_L = 1'b1;
    wait_pop(5);
    repeat (PERIOD + 3) tick();
    chk("c7_pops", pops, 32'd2);

    // 5: empty flag wiggles during SHOW_HI with nothing in the FIFO
    clear_trace();
    push(8'h6B);
    wait_pop(5);
    repeat (3) tick();
    pif.i_Fifo_Empty = 1'b0;
    #1 pif.i_Fifo_Empty = 1'b1;
    #1 pif.i_Fifo_Empty = 1'b0;
    tick();
    repeat (PERIOD + 5) tick();
    chk("glitch_pops", pops, 32'd1);

    // 6: 0x9E, 0x40 (blank gap visible when the feature is built in)
    run_pair(8'h9E, 8'h40, e6, "pair_9e40");

    // Randomised byte stream checked by the model every cycle
    clear_trace();
    for (int i = 0; i < 12; i++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2 * PERIOD)) tick();
    end
    repeat (12 * (PERIOD + 1) + 20) tick();
    chk("rand_pops", pops, 32'd12);
    chk("rand_fifo_drained", fq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
